// File: rtl/cw305_seq_pkg.sv
// cw305_seq_pkg
//   Shared types and constants for the CW305 crypto sequencer slice.
//   - seq_state_e : sequencer FSM states
//   - DEF_*       : default parameter values for widths and timeout
//   - tcnt_width  : bit width of the RUN-phase timeout counter
package cw305_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    START,
    RUN
  } seq_state_e;

  localparam int DEF_KEY_WIDTH      = 128;
  localparam int DEF_TEXT_WIDTH     = 128;
  localparam int DEF_DELAY_WIDTH    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  // Wide enough to hold the value TIMEOUT_CYCLES itself.
  function automatic int tcnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/cw305_crypto_seq_if.sv
// cw305_crypto_seq_if
//   Bus between the sequencer and the crypto core.
//   - core_key/core_text : operands latched by the sequencer
//   - core_load          : one-cycle operand load strobe
//   - core_start         : one-cycle start strobe
//   - core_done          : core completion pulse
//   - core_result        : core output, valid with core_done
//   Modports: master = sequencer side, slave = crypto core side.
interface cw305_crypto_seq_if
  import cw305_seq_pkg::*;
#(
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter int TEXT_WIDTH = DEF_TEXT_WIDTH
);

  logic [KEY_WIDTH-1:0]  core_key;
  logic [TEXT_WIDTH-1:0] core_text;
  logic                  core_load;
  logic                  core_start;
  logic                  core_done;
  logic [TEXT_WIDTH-1:0] core_result;

  modport master (
    output core_key, core_text, core_load, core_start,
    input  core_done, core_result
  );

  modport slave (
    input  core_key, core_text, core_load, core_start,
    output core_done, core_result
  );

endinterface

// File: rtl/cw305_sync_edge.sv
// cw305_sync_edge
//   Two-flop synchronizer for an asynchronous level, followed by a
//   registered rising-edge detector. A pin edge shows up on 'rise' as a
//   one-cycle pulse three clocks later.
//   Ports:
//   - clk   : clock
//   - reset : synchronous, active-high
//   - din   : asynchronous input level
//   - rise  : one-cycle pulse per synchronized rising edge
module cw305_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours; blocking here would
  // collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync_1    <= din;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      rise      <= sync_2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/cw305_crypto_seq.sv
// cw305_crypto_seq
//   Sequencer between the CW305 register bank and one crypto core.
//   On a start request (cmd_go, or a synchronized ext_trig rising edge
//   when ext_trig_en=1) it latches key/plaintext, pulses core_load, waits
//   cfg_delay cycles, pulses core_start, holds tio_trigger for the whole
//   operation and captures the result or flags a timeout.
//   Ports:
//   - clk, reset        : clock, synchronous active-high reset
//   - cmd_go            : one-cycle start pulse
//   - ext_trig          : asynchronous external trigger level
//   - ext_trig_en       : enables ext_trig rising edge as a start
//   - cfg_delay         : pre-trigger delay in cycles
//   - key_in, text_in   : operands from the register bank
//   - core              : master side of the crypto core bus
//   - result_out        : registered core result
//   - tio_trigger       : scope trigger
//   - busy              : sequencer not idle
//   - done, timeout     : outcome of the last operation
//   - overrun           : sticky, start request seen while busy
module cw305_crypto_seq
  import cw305_seq_pkg::*;
#(
  parameter int KEY_WIDTH      = DEF_KEY_WIDTH,
  parameter int TEXT_WIDTH     = DEF_TEXT_WIDTH,
  parameter int DELAY_WIDTH    = DEF_DELAY_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_go,
  input  logic                   ext_trig,
  input  logic                   ext_trig_en,
  input  logic [DELAY_WIDTH-1:0] cfg_delay,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [TEXT_WIDTH-1:0]  text_in,
  cw305_crypto_seq_if.master     core,
  output logic [TEXT_WIDTH-1:0]  result_out,
  output logic                   tio_trigger,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   overrun
);

  localparam int                TCNT_W    = tcnt_width(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES);

  seq_state_e             state;
  seq_state_e             state_next;
  logic                   trig_rise;
  logic                   start_req;
  logic [DELAY_WIDTH-1:0] dly_cnt;
  logic [TCNT_W-1:0]      tcnt;
  logic [TCNT_W-1:0]      tcnt_inc;
  logic                   run_expired;

  logic [KEY_WIDTH-1:0]   core_key_q;
  logic [TEXT_WIDTH-1:0]  core_text_q;
  logic                   core_load_q;
  logic                   core_start_q;

  cw305_sync_edge u_trig_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ext_trig),
    .rise  (trig_rise)
  );

  // cmd_go and an external edge in the same cycle merge into one request.
  assign start_req = cmd_go | (ext_trig_en & trig_rise);

  // tcnt counts RUN cycles already spent; this RUN cycle is number tcnt+1.
  assign tcnt_inc    = tcnt + TCNT_W'(1);
  assign run_expired = (tcnt_inc == TCNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start_req) state_next = LOAD;
      LOAD:  state_next = (dly_cnt != '0) ? ARM : START;
      // Leave ARM on the cycle the counter steps from 1 to 0.
      ARM:   if (dly_cnt == DELAY_WIDTH'(1)) state_next = START;
      START: state_next = RUN;
      RUN:   if (core.core_done || run_expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from state_next and registered, so they line up
  // with the state register and never see a combinational input path.
  // NOTE: the operand and result registers are reset too, because the
  // register bank must read zeros after reset, not stale operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_key_q   <= '0;
      core_text_q  <= '0;
      core_load_q  <= 1'b0;
      core_start_q <= 1'b0;
      tio_trigger  <= 1'b0;
      busy         <= 1'b0;
      result_out   <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
      dly_cnt      <= '0;
      tcnt         <= '0;
    end else begin
      core_load_q  <= (state_next == LOAD);
      core_start_q <= (state_next == START);
      tio_trigger  <= (state_next == START) || (state_next == RUN);
      busy         <= (state_next != IDLE);

      unique case (state)
        IDLE: begin
          if (start_req) begin
            core_key_q  <= key_in;
            core_text_q <= text_in;
            done        <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
            dly_cnt     <= cfg_delay;
          end
        end
        ARM:   dly_cnt <= dly_cnt - DELAY_WIDTH'(1);
        START: tcnt    <= '0;
        RUN: begin
          tcnt <= tcnt_inc;
          if (core.core_done) begin
            result_out <= core.core_result;
            done       <= 1'b1;
          end else if (run_expired) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase

      // Requests outside IDLE are dropped but remembered.
      if (start_req && (state != IDLE)) overrun <= 1'b1;
    end
  end

  assign core.core_key   = core_key_q;
  assign core.core_text  = core_text_q;
  assign core.core_load  = core_load_q;
  assign core.core_start = core_start_q;

endmodule

// File: tb/tb_cw305_crypto_seq.sv
// tb_cw305_crypto_seq
//   Scoreboard bench: each issued operation pushes its expectation (operands,
//   cycle of load, delay, core latency, result) into a queue; a monitor on
//   the falling edge checks strobe timing, operands and the final outcome.
//   A small core model answers core_start after a chosen latency (0 = never).
module tb_cw305_crypto_seq;

  localparam int T = 8;

  typedef struct {
    logic [127:0] key;
    logic [127:0] text;
    logic [127:0] result;
    int           delay;
    int           lat;
    int           load_cyc;
    bit           ovr;
  } op_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_go;
  logic         ext_trig;
  logic         ext_trig_en;
  logic [15:0]  cfg_delay;
  logic [127:0] key_in;
  logic [127:0] text_in;
  logic [127:0] result_out;
  logic         tio_trigger;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         overrun;

  cw305_crypto_seq_if #(.KEY_WIDTH(128), .TEXT_WIDTH(128)) core_bus ();

  cw305_crypto_seq #(
    .KEY_WIDTH      (128),
    .TEXT_WIDTH     (128),
    .DELAY_WIDTH    (16),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_go      (cmd_go),
    .ext_trig    (ext_trig),
    .ext_trig_en (ext_trig_en),
    .cfg_delay   (cfg_delay),
    .key_in      (key_in),
    .text_in     (text_in),
    .core        (core_bus),
    .result_out  (result_out),
    .tio_trigger (tio_trigger),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  op_t          exp_q[$];
  int           lat_q[$];
  logic [127:0] res_q[$];
  logic [127:0] last_result = '0;
  bit           mon_en = 1'b0;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural crypto core: done after 'lat' cycles, or never when lat=0.
  initial begin
    int           l;
    logic [127:0] r;
    core_bus.core_done   = 1'b0;
    core_bus.core_result = rand128();
    forever begin
      @(negedge clk);
      if (core_bus.core_start && lat_q.size() > 0) begin
        l = lat_q.pop_front();
        r = res_q.pop_front();
        if (l > 0) begin
          repeat (l) @(posedge clk);
          #1;
          core_bus.core_done   = 1'b1;
          core_bus.core_result = r;
          @(posedge clk);
          #1;
          core_bus.core_done   = 1'b0;
          core_bus.core_result = rand128();
        end
      end
    end
  end

  // Monitor: strobe timing and operands, then outcome when busy falls.
  bit prev_busy = 1'b0;
  int tio_cnt   = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (tio_trigger) tio_cnt++;
      if (core_bus.core_load) begin
        tio_cnt = 0;
        if (exp_q.size() == 0) check("spurious_load", core_bus.core_load, 1'b0);
        else begin
          check("load_cycle", cyc, exp_q[0].load_cyc);
          check("load_key", core_bus.core_key, exp_q[0].key);
          check("load_text", core_bus.core_text, exp_q[0].text);
          check("load_busy", busy, 1'b1);
          check("load_overrun_clr", overrun, 1'b0);
        end
      end
      if (core_bus.core_start) begin
        if (exp_q.size() == 0) check("spurious_start", core_bus.core_start, 1'b0);
        else begin
          check("start_cycle", cyc, exp_q[0].load_cyc + 1 + exp_q[0].delay);
          check("start_key_held", core_bus.core_key, exp_q[0].key);
          check("start_tio", tio_trigger, 1'b1);
        end
      end
      if (prev_busy && !busy && exp_q.size() > 0) begin
        op_t e;
        int  st;
        int  en;
        e  = exp_q.pop_front();
        st = e.load_cyc + 1 + e.delay;
        en = st + ((e.lat == 0) ? T : e.lat) + 1;
        if (e.lat != 0) last_result = e.result;
        check("end_cycle", cyc, en);
        check("end_done", done, e.lat != 0);
        check("end_timeout", timeout, e.lat == 0);
        check("end_result", result_out, last_result);
        check("end_overrun", overrun, e.ovr);
        check("end_tio_low", tio_trigger, 1'b0);
        check("tio_width", tio_cnt, en - st);
      end
    end
    prev_busy = busy;
  end

  task automatic step(input int from_cyc);
    @(posedge clk);
    #1;
    // Operands are rewritten once latched; they must not reach the core.
    if (cyc >= from_cyc) begin
      key_in    = rand128();
      text_in   = rand128();
      cfg_delay = 16'($urandom);
    end
  endtask

  task automatic run_op(input logic [127:0] k, input logic [127:0] t, input logic [127:0] r,
                        input int d, input int l, input bit ext, input bit ovr);
    op_t e;
    int  c;
    @(posedge clk);
    #1;
    key_in    = k;
    text_in   = t;
    cfg_delay = 16'(d);
    c = cyc;
    e.key = k; e.text = t; e.result = r; e.delay = d; e.lat = l; e.ovr = ovr;
    if (ext) begin
      ext_trig_en = 1'b1;
      ext_trig    = 1'b1;
      e.load_cyc  = c + 4;
    end else begin
      cmd_go     = 1'b1;
      e.load_cyc = c + 1;
    end
    exp_q.push_back(e);
    lat_q.push_back(l);
    res_q.push_back(r);
    step(e.load_cyc);
    cmd_go = 1'b0;
    if (ext) begin
      step(e.load_cyc);
      ext_trig = 1'b0;
    end
    if (ovr) begin
      // Request during the first RUN cycle.
      while (cyc < e.load_cyc + d + 2) step(e.load_cyc);
      cmd_go = 1'b1;
      step(e.load_cyc);
      cmd_go = 1'b0;
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step(e.load_cyc);
    if (exp_q.size() != 0) begin
      check("op_completion", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) step(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    reset       = 1'b1;
    cmd_go      = 1'b0;
    ext_trig    = 1'b0;
    ext_trig_en = 1'b0;
    cfg_delay   = '0;
    key_in      = rand128();
    text_in     = rand128();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_tio", tio_trigger, 1'b0);
    check("rst_flags", {done, timeout, overrun}, 3'b000);
    check("rst_strobes", {core_bus.core_load, core_bus.core_start}, 2'b00);
    check("rst_result", result_out, '0);
    check("rst_key", core_bus.core_key, '0);
    check("rst_text", core_bus.core_text, '0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Zero delay, known operands, done three cycles after start.
    run_op(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 3, 1'b0, 1'b0);
    check("aes_result", result_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("aes_done", done, 1'b1);

    // Ten-cycle pre-trigger delay with operand rewrites during ARM.
    run_op(rand128(), rand128(), rand128(), 10, 2, 1'b0, 1'b0);
    // External trigger start.
    run_op(rand128(), rand128(), rand128(), 1, 4, 1'b1, 1'b0);

    // External trigger disabled: no activity.
    ext_trig_en = 1'b0;
    ext_trig    = 1'b1;
    repeat (2) step(0);
    ext_trig = 1'b0;
    repeat (6) step(0);
    check("ext_disabled_busy", busy, 1'b0);

    // Overrun during RUN, then a clean operation clears it.
    run_op(rand128(), rand128(), rand128(), 2, 5, 1'b0, 1'b1);
    run_op(rand128(), rand128(), rand128(), 0, 1, 1'b0, 1'b0);
    // Timeout and done on the very last RUN cycle.
    run_op(rand128(), rand128(), rand128(), 3, 0, 1'b0, 1'b0);
    run_op(rand128(), rand128(), rand128(), 0, T, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      run_op(rand128(), rand128(), rand128(), $urandom_range(0, 20), $urandom_range(0, T),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset in the middle of RUN.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    cfg_delay = '0;
    cmd_go    = 1'b1;
    lat_q.push_back(0);
    res_q.push_back('0);
    @(posedge clk);
    #1;
    cmd_go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_run", tio_trigger, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tio", tio_trigger, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result_out, '0);
    check("midrst_key", core_bus.core_key, '0);
    strobes = 0;
    repeat (10) begin
      @(negedge clk);
      if (core_bus.core_load || core_bus.core_start || busy) strobes++;
    end
    check("midrst_no_strobes", strobes, 0);
    last_result = '0;
    mon_en      = 1'b1;

    run_op(rand128(), rand128(), rand128(), 4, 3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cw305_crypto_seq.md
# cw305_crypto_seq

Sequencer between the CW305 USB register bank and a single crypto core on the same clock. It latches key and plaintext from the register bank and loads them into the core. After a programmable pre-trigger delay it starts the core, drives the scope trigger pin for the duration of the operation, and writes the result and status back to the register bank. Start comes from a register-write strobe or from the external USB trigger line.

## Interface
Parameters:
- KEY_WIDTH, 128, key width in bits
- TEXT_WIDTH, 128, plaintext/ciphertext width in bits
- DELAY_WIDTH, 16, width of pre-trigger delay configuration
- TIMEOUT_CYCLES, 65535, maximum RUN cycles before abort; ≥1

Ports:
- clk  in  1  single clock for the whole block; shared with the crypto core
- reset  in  1  synchronous, active-high
- cmd_go  in  1  one-cycle start pulse from register-write decode
- ext_trig  in  1  asynchronous external trigger level (USB trigger pin)
- ext_trig_en  in  1  1 = rising edge of ext_trig also starts
- cfg_delay  in  DELAY_WIDTH  pre-trigger delay in cycles
- key_in  in  KEY_WIDTH  key from register bank
- text_in  in  TEXT_WIDTH  plaintext from register bank
- core_key  out  KEY_WIDTH  latched key to core
- core_text  out  TEXT_WIDTH  latched plaintext to core
- core_load  out  1  one-cycle load strobe to core
- core_start  out  1  one-cycle start strobe to core
- core_done  in  1  core completion pulse
- core_result  in  TEXT_WIDTH  core output, valid with core_done
- result_out  out  TEXT_WIDTH  registered result to register bank
- tio_trigger  out  1  scope trigger
- busy  out  1  state ≠ IDLE
- done  out  1  last operation completed
- timeout  out  1  last operation aborted by timeout
- overrun  out  1  sticky; start request seen while busy

## Operation
- Reset: state IDLE; every output 0, including core_key/core_text/result_out and all flags.
- Start request:
  - Asserted by cmd_go, or by a synchronized ext_trig rising edge when ext_trig_en = 1.
  - If both arrive in the same cycle, they count as one request.
- IDLE, on start request:
  - Latch key_in/text_in into core_key/core_text.
  - Clear done, timeout and overrun.
  - Load the delay counter with cfg_delay.
  - Go to LOAD.
- LOAD: core_load = 1 for exactly one cycle. Go to ARM if the delay is ≠ 0, else START.
- ARM: decrement the counter each cycle. Go to START on the cycle it reaches 0. ARM lasts exactly cfg_delay cycles.
- START:
  - core_start = 1 for one cycle and tio_trigger = 1.
  - Clear the timeout counter and go to RUN.
- RUN: tio_trigger stays 1, the timeout counter increments, and core_done is sampled.
  - core_done = 1 → register core_result into result_out, set done, go to IDLE.
  - Counter = TIMEOUT_CYCLES with no done → set timeout, go to IDLE. result_out is left unchanged and done stays 0.
- core_done in START is ignored. The core contract requires ≥1 cycle of latency.
- Start request in any state other than IDLE: ignored and sets overrun. overrun is cleared only by reset or by the next accepted start.
- cfg_delay/key_in/text_in changes after latching have no effect on the operation in progress.
- reset asserted mid-operation: next cycle is IDLE, all outputs 0, and no further core strobes are issued. The core itself must be reset by the same signal.

## Timing
- Accepted cmd_go at cycle 0 (IDLE):
  - core_load high in cycle 1.
  - core_start and tio_trigger rise in cycle 2 + cfg_delay.
- ext_trig path:
  - 2-FF synchronizer plus an edge register give 3 cycles from a pin edge to the request.
  - The ext_trig pulse must be ≥2 clk high and ≥2 clk low.
- core_done in cycle N (RUN):
  - result_out/done valid in cycle N+1.
  - tio_trigger low in cycle N+1.
  - busy low in cycle N+1.
- A new start is accepted in cycle N+1 at the earliest.
- Timeout: with no done, RUN lasts TIMEOUT_CYCLES cycles; timeout = 1 and tio_trigger = 0 on the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package cw305_seq_pkg:
  - State enum: IDLE, LOAD, ARM, START, RUN.
  - Default width constants.
  - Timeout counter width: $clog2(TIMEOUT_CYCLES+1).
- Sub-module cw305_sync_edge: 2-FF synchronizer plus rising-edge detect, with clk/reset. Used for ext_trig.
- The remainder is one FSM with its counters in cw305_crypto_seq.

## Test plan
- Reset mid-RUN: assert reset for 1 cycle during RUN → next cycle IDLE; busy = tio_trigger = done = 0 and result_out = 0.
- Zero-delay start:
  - Stimulus: cfg_delay = 0, key = 0x000102…0F, text = 0x00112233…FF, cmd_go at cycle 0, core_done with result 0x69C4E0D8…C55A at cycle 5.
  - Response: core_load at cycle 1, core_start at cycle 2, tio_trigger high cycles 2–5, result_out = 0x69C4E0D8…C55A and done = 1 at cycle 6.
- Delay count: cfg_delay = 10 → core_start exactly at cycle 12; core_key unchanged after key_in is rewritten during ARM.
- External trigger:
  - ext_trig_en = 1 with a rising ext_trig at cycle 0 → core_load at cycle 4.
  - Same stimulus with ext_trig_en = 0 → no activity.
- Overrun: cmd_go during RUN → overrun = 1 and the operation completes normally; the next accepted cmd_go clears overrun.
- Timeout: TIMEOUT_CYCLES = 8, core_done never asserted → timeout = 1, done = 0, result_out unchanged, and busy low exactly 9 cycles after core_start.
